// File: rtl/fifo_ctrl_dual_pop_if.sv
// Handshake bundle between a FIFO producer/consumer and the dual-pop pointer controller.
// master: the side issuing push/pop/clear requests; slave: the controller itself.
interface fifo_ctrl_dual_pop_if #(
    parameter int unsigned ADDR_WIDTH = 3
) ();
    logic                  clr;
    logic                  push;
    logic [1:0]            pop_cnt;
    logic                  we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr0;
    logic [ADDR_WIDTH-1:0] r_addr1;
    logic [ADDR_WIDTH:0]   count;
    logic                  empty;
    logic                  full;
    logic                  two_avail;
    logic                  ovf;
    logic                  udf;

    modport master (
        output clr, push, pop_cnt,
        input  we, w_addr, r_addr0, r_addr1, count, empty, full, two_avail, ovf, udf
    );

    modport slave (
        input  clr, push, pop_cnt,
        output we, w_addr, r_addr0, r_addr1, count, empty, full, two_avail, ovf, udf
    );
endinterface

// File: rtl/fifo_ctrl_dual_pop.sv
// Pointer/flag controller for a 1-write/2-read register-file RAM used as a circular FIFO.
// Read port 0 addresses the head, read port 1 the entry after it, so the consumer may pop
// one or two words per cycle. All flags decode from registers only.
module fifo_ctrl_dual_pop #(
    parameter int unsigned ADDR_WIDTH = 3
) (
    input logic                 clk,
    input logic                 reset_n,
    fifo_ctrl_dual_pop_if.slave bus
);
    localparam int unsigned PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PW-1:0] ONE   = PW'(1);
    localparam logic [PW-1:0] TWO   = PW'(2);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic          full;
    logic          push_acc;
    logic [1:0]    pop_n;
    logic          pop_rej;

    // Status flags, decoded purely from the occupancy register.
    always_comb begin
        full          = (count_q == DEPTH);
        bus.empty     = (count_q == '0);
        bus.full      = full;
        bus.two_avail = (count_q >= TWO);
        bus.count     = count_q;
        bus.ovf       = ovf_q;
        bus.udf       = udf_q;
    end

    // Acceptance: push uses current-cycle full only; pops are all-or-nothing.
    always_comb begin
        push_acc = bus.push & ~full & ~bus.clr;
        pop_n    = 2'd0;
        pop_rej  = 1'b0;
        case (bus.pop_cnt)
            2'd1: begin
                if (count_q >= ONE) pop_n   = 2'd1;
                else                pop_rej = 1'b1;
            end
            2'd2: begin
                if (count_q >= TWO) pop_n   = 2'd2;
                else                pop_rej = 1'b1;
            end
            2'd3:    pop_rej = 1'b1;
            default: ;
        endcase
    end

    // RAM-side addresses and write strobe.
    always_comb begin
        bus.we      = push_acc;
        bus.w_addr  = wr_ptr_q[ADDR_WIDTH-1:0];
        bus.r_addr0 = rd_ptr_q[ADDR_WIDTH-1:0];
        bus.r_addr1 = rd_ptr_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
    end

    // Next-state: clear returns everything to the reset state and overrides traffic.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_acc);
        rd_ptr_d = rd_ptr_q + PW'(pop_n);
        count_d  = count_q + PW'(push_acc) - PW'(pop_n);
        ovf_d    = ovf_q | (bus.push & full);
        udf_d    = udf_q | pop_rej;
        if (bus.clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Occupancy register must always agree with the wrap-bit pointer distance.
    ptr_count_consistent_a: assert property (
        @(posedge clk) disable iff (!reset_n) count_q == (wr_ptr_q - rd_ptr_q)
    );
endmodule

// File: tb/tb_fifo_ctrl_dual_pop.sv
// Self-checking bench for fifo_ctrl_dual_pop: a directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based FIFO model.
module tb_fifo_ctrl_dual_pop;
    localparam int AW = 3;
    localparam int D  = 8;

    logic clk = 1'b0;
    logic reset_n;

    fifo_ctrl_dual_pop_if #(.ADDR_WIDTH(AW)) bus ();

    fifo_ctrl_dual_pop #(.ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model: queue of stored words (its size is the occupancy), head slot index, sticky flags.
    int q[$];
    int m_head;
    bit m_ovf, m_udf;
    int ram[D];
    bit last_we;

    typedef struct {
        bit       push;
        bit [1:0] pop;
        bit       clr;
        bit       we;
        int       count;
        int       r0;
        bit       udf;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_head = 0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    task automatic check_outputs(input bit p, input bit c);
        int n;
        n = q.size();
        chk("count", int'(bus.count), n);
        chk("empty", int'(bus.empty), int'(n == 0));
        chk("full", int'(bus.full), int'(n == D));
        chk("two_avail", int'(bus.two_avail), int'(n >= 2));
        chk("ovf", int'(bus.ovf), int'(m_ovf));
        chk("udf", int'(bus.udf), int'(m_udf));
        chk("w_addr", int'(bus.w_addr), (m_head + n) % D);
        chk("r_addr0", int'(bus.r_addr0), m_head);
        chk("r_addr1", int'(bus.r_addr1), (m_head + 1) % D);
        chk("we", int'(bus.we), int'(p && !c && n < D));
    endtask

    task automatic step(input bit p, input bit [1:0] pc, input bit c);
        int  pn;
        int  wdata;
        bit  acc;
        bit  we_s;
        int  wa;
        @(negedge clk);
        bus.push    = p;
        bus.pop_cnt = pc;
        bus.clr     = c;
        #1;
        check_outputs(p, c);
        acc = p && !c && (q.size() < D);
        pn  = 0;
        if (pc == 2'd1 && q.size() >= 1) pn = 1;
        if (pc == 2'd2 && q.size() >= 2) pn = 2;
        if (!c && pn >= 1) chk("rdata0", ram[bus.r_addr0], q[0]);
        if (!c && pn == 2) chk("rdata1", ram[bus.r_addr1], q[1]);
        wdata   = int'($urandom);
        we_s    = bus.we;
        last_we = we_s;
        wa      = int'(bus.w_addr);
        @(posedge clk);
        if (we_s) ram[wa] = wdata;
        if (c) begin
            model_reset();
        end else begin
            if (p && q.size() == D) m_ovf = 1'b1;
            if (pc != 2'd0 && pn == 0) m_udf = 1'b1;
            repeat (pn) void'(q.pop_front());
            if (acc) q.push_back(wdata);
            m_head = (m_head + pn) % D;
        end
    endtask

    // Pulse reset low between clock edges; outputs must return to reset values immediately.
    task automatic do_reset();
        @(negedge clk);
        bus.push    = 1'b0;
        bus.pop_cnt = 2'd0;
        bus.clr     = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs(1'b0, 1'b0);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        int x;
        bit [1:0] pc;
        reset_n     = 1'b0;
        bus.push    = 1'b0;
        bus.pop_cnt = 2'd0;
        bus.clr     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_empty", int'(bus.empty), 1);
        chk("reset_r_addr1", int'(bus.r_addr1), 1);
        reset_n = 1'b1;
        step(1'b0, 2'd0, 1'b0);

        // push, pop, clr, we, count-after, r_addr0-after, udf-after
        tbl = '{
            '{1'b1, 2'd0, 1'b0, 1'b1, 1, 0, 1'b0},
            '{1'b1, 2'd1, 1'b0, 1'b1, 1, 1, 1'b0},
            '{1'b0, 2'd2, 1'b0, 1'b0, 1, 1, 1'b1},
            '{1'b1, 2'd3, 1'b0, 1'b1, 2, 1, 1'b1},
            '{1'b0, 2'd2, 1'b0, 1'b0, 0, 3, 1'b1},
            '{1'b1, 2'd1, 1'b0, 1'b1, 1, 3, 1'b1},
            '{1'b1, 2'd1, 1'b1, 1'b0, 0, 0, 1'b0}
        };
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].push, tbl[i].pop, tbl[i].clr);
            #1;
            chk($sformatf("tbl%0d_we", i), int'(last_we), int'(tbl[i].we));
            chk($sformatf("tbl%0d_count", i), int'(bus.count), tbl[i].count);
            chk($sformatf("tbl%0d_r_addr0", i), int'(bus.r_addr0), tbl[i].r0);
            chk($sformatf("tbl%0d_udf", i), int'(bus.udf), int'(tbl[i].udf));
        end

        // Fill to full, then overflow.
        do_reset();
        repeat (8) step(1'b1, 2'd0, 1'b0);
        #1;
        chk("fill_count", int'(bus.count), 8);
        chk("fill_full", int'(bus.full), 1);
        chk("fill_w_addr", int'(bus.w_addr), 0);
        step(1'b1, 2'd0, 1'b0);
        #1;
        chk("ovf_we", int'(last_we), 0);
        chk("ovf_count", int'(bus.count), 8);
        chk("ovf_flag", int'(bus.ovf), 1);

        // Dual pop, rejected dual pop, single pop.
        do_reset();
        repeat (3) step(1'b1, 2'd0, 1'b0);
        step(1'b0, 2'd2, 1'b0);
        #1;
        chk("dp_count", int'(bus.count), 1);
        chk("dp_r_addr0", int'(bus.r_addr0), 2);
        chk("dp_r_addr1", int'(bus.r_addr1), 3);
        step(1'b0, 2'd2, 1'b0);
        #1;
        chk("dp_rej_count", int'(bus.count), 1);
        chk("dp_rej_udf", int'(bus.udf), 1);
        step(1'b0, 2'd1, 1'b0);
        #1;
        chk("dp_last_empty", int'(bus.empty), 1);

        // Wrap-around of the read address pair.
        do_reset();
        repeat (8) step(1'b1, 2'd0, 1'b0);
        repeat (7) step(1'b0, 2'd1, 1'b0);
        repeat (2) step(1'b1, 2'd0, 1'b0);
        #1;
        chk("wrap_count", int'(bus.count), 3);
        chk("wrap_r_addr0", int'(bus.r_addr0), 7);
        chk("wrap_r_addr1", int'(bus.r_addr1), 0);
        step(1'b0, 2'd2, 1'b0);
        #1;
        chk("wrap_pop_r_addr0", int'(bus.r_addr0), 1);
        chk("wrap_pop_count", int'(bus.count), 1);

        // Simultaneous push and pop.
        do_reset();
        repeat (4) step(1'b1, 2'd0, 1'b0);
        step(1'b1, 2'd2, 1'b0);
        #1;
        chk("sim_count3", int'(bus.count), 3);
        repeat (5) step(1'b1, 2'd0, 1'b0);
        step(1'b1, 2'd1, 1'b0);
        #1;
        chk("sim_full_count", int'(bus.count), 7);
        chk("sim_full_ovf", int'(bus.ovf), 1);
        do_reset();
        step(1'b1, 2'd1, 1'b0);
        #1;
        chk("sim_empty_count", int'(bus.count), 1);
        chk("sim_empty_udf", int'(bus.udf), 1);

        // Clear with a push pending, then the same state cut short by an async reset.
        do_reset();
        repeat (9) step(1'b1, 2'd0, 1'b0);
        repeat (3) step(1'b0, 2'd1, 1'b0);
        step(1'b1, 2'd0, 1'b1);
        #1;
        chk("clr_we", int'(last_we), 0);
        chk("clr_count", int'(bus.count), 0);
        chk("clr_empty", int'(bus.empty), 1);
        chk("clr_ovf", int'(bus.ovf), 0);
        repeat (9) step(1'b1, 2'd0, 1'b0);
        repeat (3) step(1'b0, 2'd1, 1'b0);
        do_reset();
        #0;
        chk("rst_count", int'(bus.count), 0);
        chk("rst_ovf", int'(bus.ovf), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            x = int'($urandom_range(0, 199));
            if (x < 2) begin
                do_reset();
            end else begin
                x  = int'($urandom_range(0, 19));
                pc = (x < 7) ? 2'd0 : (x < 13) ? 2'd1 : (x < 19) ? 2'd2 : 2'd3;
                step($urandom_range(0, 99) < 55, pc, $urandom_range(0, 99) < 2);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
